complex_sq_sched: RTL and testbench

COMPLEX_SQ_SCHED -- requirements
Module: complex_sq_sched

---
 rtl/csq_pkg.sv | 13 +
 rtl/complex_sq_sched_rr_arbiter.sv | 26 ++
 rtl/complex_sq_sched.sv | 93 +++++++++
 tb/tb_complex_sq_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csq_pkg.sv
// Shared defaults and helpers for the complex-square scheduler.
package csq_pkg;
  localparam int CSQ_WIDTH  = 16;
  localparam int CSQ_NREQ   = 4;
  localparam int CSQ_STAT_W = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/complex_sq_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted req at index >= ptr, wrapping.
module rr_arbiter
  import csq_pkg::*;
#(
  parameter int NREQ = CSQ_NREQ,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (grant == '0 && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/complex_sq_sched.sv
// Round-robin scheduler feeding a 2-stage complex-square pipeline (a+jb)^2.
// Optional per-requester result counters when CSQ_STATS_EN is defined.
module complex_sq_sched
  import csq_pkg::*;
#(
  parameter  int WIDTH = CSQ_WIDTH,
  parameter  int NREQ  = CSQ_NREQ,
  localparam int IDW   = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       reqValid,
  output logic [NREQ-1:0]       reqReady,
  input  logic [NREQ*WIDTH-1:0] reqReal,
  input  logic [NREQ*WIDTH-1:0] reqImag,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [IDW-1:0]        outId,
  output logic [WIDTH-1:0]      outReal,
  output logic [WIDTH-1:0]      outImag,
`ifdef CSQ_STATS_EN
  output logic [NREQ*CSQ_STAT_W-1:0] opCount,
`endif
  output logic                  busy
);
  logic [2:1]              vld_pipe;
  logic [NREQ-1:0]         grant;
  logic [IDW-1:0]          gidx, ptr, s1_id;
  logic signed [WIDTH-1:0] s1_a, s1_b, sel_a, sel_b;
  logic signed [2*WIDTH:0] ax, bx, sq_re, sq_im;
  logic                    s2_adv, s1_load, xfer;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(reqValid), .ptr(ptr), .grant(grant), .idx(gidx)
  );

  always_comb begin
    s2_adv   = !vld_pipe[2] || outReady;
    s1_load  = !vld_pipe[1] || s2_adv;
    xfer     = !rst && s1_load && (|reqValid);
    reqReady = xfer ? grant : '0;
    sel_a    = reqReal[int'(gidx)*WIDTH +: WIDTH];
    sel_b    = reqImag[int'(gidx)*WIDTH +: WIDTH];
    // Full-precision square; only the low WIDTH bits leave the block.
    ax       = (2*WIDTH+1)'(s1_a);
    bx       = (2*WIDTH+1)'(s1_b);
    sq_re    = ax * ax - bx * bx;
    sq_im    = (ax * bx) <<< 1;
  end

  assign outValid = vld_pipe[2];
  assign busy     = |vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      ptr      <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      outReal  <= '0;
      outImag  <= '0;
      outId    <= '0;
    end else begin
      if (s1_load) vld_pipe[1] <= xfer;
      if (xfer) begin
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_id <= gidx;
        ptr   <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          outReal <= sq_re[WIDTH-1:0];
          outImag <= sq_im[WIDTH-1:0];
          outId   <= s1_id;
        end
      end
    end
  end

`ifdef CSQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) opCount <= '0;
    else if (vld_pipe[2] && outReady) begin
      for (int i = 0; i < NREQ; i++)
        if (outId == IDW'(i) && opCount[i*CSQ_STAT_W +: CSQ_STAT_W] != '1)
          opCount[i*CSQ_STAT_W +: CSQ_STAT_W] <= opCount[i*CSQ_STAT_W +: CSQ_STAT_W] + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_complex_sq_sched.sv
// Bench for complex_sq_sched: vector table, scoreboard monitor, corner sequences.
module tb_complex_sq_sched;
  import csq_pkg::*;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int IDW = clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   reqValid, reqReady;
  logic [N*W-1:0] reqReal, reqImag;
  logic           outValid, outReady, busy;
  logic [IDW-1:0] outId;
  logic [W-1:0]   outReal, outImag;
`ifdef CSQ_STATS_EN
  logic [N*16-1:0] opCount;
`endif

  complex_sq_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
    .reqReal(reqReal), .reqImag(reqImag), .outValid(outValid),
    .outReady(outReady), .outId(outId), .outReal(outReal), .outImag(outImag),
`ifdef CSQ_STATS_EN
    .opCount(opCount),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IDW-1:0] id; logic [W-1:0] re, im; } exp_t;
  typedef struct { logic [W-1:0] a, b, re, im; } vec_t;

  exp_t           sb[$];
  int             checks = 0, errors = 0;
  logic [IDW-1:0] mptr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    longint la, lb;
    exp_t e;
    la = a; lb = b;
    e.id = IDW'(id);
    e.re = W'(la * la - lb * lb);
    e.im = W'(2 * la * lb);
    return e;
  endfunction

  // Scoreboard: expected results queued on each transfer, checked on each output beat.
  always @(negedge clk) begin
    int g, a;
    exp_t e;
    if (!rst) begin
      if (|reqReady) begin
        g = -1; a = -1;
        for (int k = 0; k < N; k++) begin
          if (g < 0 && reqValid[(int'(mptr) + k) % N]) g = (int'(mptr) + k) % N;
          if (reqReady[k]) a = k;
        end
        chk("ready_onehot", 32'($onehot(reqReady)), 1);
        chk("grant_idx", a, g);
        if (g >= 0) begin
          sb.push_back(model(g, reqReal[g*W +: W], reqImag[g*W +: W]));
          mptr = IDW'((g + 1) % N);
        end
      end
      if (outValid && outReady) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: id %0d re %0h with empty scoreboard", outId, outReal);
        end else begin
          e = sb.pop_front();
          chk("sb_id", outId, e.id);
          chk("sb_re", outReal, e.re);
          chk("sb_im", outImag, e.im);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    reqReal = {$urandom, $urandom};
    reqImag = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b1; sb.delete(); mptr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_done", (sb.size() == 0 && !busy), 1);
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  vec_t vt[8];
  logic [W-1:0] fr_re, fr_im;
  logic [IDW-1:0] fr_id;

  initial begin
    vt[0] = '{16'd3,     16'd4,     16'hFFF9, 16'd24};
    vt[1] = '{16'h8000,  16'd0,     16'd0,    16'd0};
    vt[2] = '{16'd16384, 16'd16384, 16'd0,    16'd0};
    vt[3] = '{16'd255,   16'd1,     16'hFE00, 16'd510};
    vt[4] = '{16'd32767, 16'd32767, 16'd0,    16'd2};
    vt[5] = '{16'hFFFD,  16'hFFFC,  16'hFFF9, 16'd24};
    vt[6] = '{16'd1,     16'hFFFF,  16'd0,    16'hFFFE};
    vt[7] = '{16'd0,     16'd0,     16'd0,    16'd0};

    // Reset state, with requests pending to prove reqReady is gated.
    rst = 1'b1; reqValid = '1; outReady = 1'b1;
    reqReal = {$urandom, $urandom}; reqImag = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    chk("rst_outValid", outValid, 0);
    chk("rst_reqReady", reqReady, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outReal", outReal, 0);
    chk("rst_outImag", outImag, 0);
    chk("rst_outId", outId, 0);
    @(posedge clk); #1;
    reqValid = '0; rst = 1'b0;
    @(negedge clk);
    chk("idle_reqReady", reqReady, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;

    // Single-shot vectors: exact two-cycle latency and table results.
    for (int t = 0; t < 8; t++) begin
      reqReal[(t%N)*W +: W] = vt[t].a;
      reqImag[(t%N)*W +: W] = vt[t].b;
      reqValid = 4'(1 << (t % N));
      @(negedge clk);
      chk("vec_ready", reqReady, 1 << (t % N));
      @(posedge clk); #1;
      reqValid = '0;
      @(negedge clk);
      chk("vec_lat1", outValid, 0);
      @(negedge clk);
      chk("vec_valid", outValid, 1);
      chk("vec_re", outReal, vt[t].re);
      chk("vec_im", outImag, vt[t].im);
      chk("vec_id", outId, t % N);
      @(posedge clk); #1;
    end
    drain();

    // Fairness: all requesters held high, one grant per cycle in order.
    do_reset();
    reqValid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", reqReady, 1 << (k % 4));
      cyc();
    end
    reqValid = '0;
    drain();

    // Backpressure: outputs frozen, intake stops once S1 fills.
    do_reset();
    outReady = 1'b0; reqValid = '1;
    @(negedge clk); chk("bp_ready0", reqReady, 4'b0001); cyc();
    @(negedge clk); chk("bp_ready1", reqReady, 4'b0010); cyc();
    @(negedge clk);
    chk("bp_ready_stall", reqReady, 0);
    chk("bp_valid", outValid, 1);
    fr_re = outReal; fr_im = outImag; fr_id = outId;
    cyc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_ready_stall", reqReady, 0);
      chk("bp_frozen_re", outReal, fr_re);
      chk("bp_frozen_im", outImag, fr_im);
      chk("bp_frozen_id", outId, fr_id);
      cyc();
    end
    outReady = 1'b1;
    repeat (6) cyc();
    reqValid = '0;
    drain();

    // Reset with both stages full: nothing emerges afterwards, ptr restarts.
    do_reset();
    outReady = 1'b0; reqValid = '1;
    repeat (3) cyc();
    chk("mid_busy", busy, 1);
    rst = 1'b1; sb.delete(); mptr = '0;
    @(negedge clk);
    chk("mid_rst_valid", outValid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", reqReady, 0);
    @(posedge clk); #1;
    rst = 1'b0; reqValid = '0; outReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", outValid, 0);
    end
    @(posedge clk); #1;
    reqValid = 4'b0101;
    @(negedge clk);
    chk("ptr_restart", reqReady, 4'b0001);
    @(posedge clk); #1;
    reqValid = '0;
    drain();

`ifdef CSQ_STATS_EN
    do_reset();
    reqValid = 4'b0100;
    repeat (70000) cyc();
    reqValid = '0;
    drain();
    chk("stat_sat2", opCount[2*16 +: 16], 16'hFFFF);
    chk("stat_cnt0", opCount[0 +: 16], 0);
    chk("stat_cnt1", opCount[16 +: 16], 0);
    chk("stat_cnt3", opCount[48 +: 16], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
